// File: rtl/n64_pkg.sv
// N64 controller response constants: command codes, info reply, reply lengths.
// Latency: n/a (constants and a pure decode function).
// Backpressure: n/a.
package n64_pkg;

    localparam logic [7:0] CMD_INFO   = 8'h00;
    localparam logic [7:0] CMD_STATUS = 8'h01;
    localparam logic [7:0] CMD_READ   = 8'h02;
    localparam logic [7:0] CMD_WRITE  = 8'h03;
    localparam logic [7:0] CMD_RESET  = 8'hFF;

    // Identity reply: standard controller, no pak status bits set.
    localparam logic [7:0] INFO_B0 = 8'h05;
    localparam logic [7:0] INFO_B1 = 8'h00;
    localparam logic [7:0] INFO_B2 = 8'h02;

    localparam logic [5:0] LEN_NONE   = 6'd0;
    localparam logic [5:0] LEN_INFO   = 6'd3;
    localparam logic [5:0] LEN_STATUS = 6'd4;
    localparam logic [5:0] LEN_READ   = 6'd33;
    localparam logic [5:0] LEN_WRITE  = 6'd1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TURN,
        ST_LOW,
        ST_HIGH,
        ST_STOP
    } tx_state_t;

    // Number of response bytes for a command; zero means "do not answer".
    function automatic logic [5:0] resp_len(input logic [7:0] c);
        case (c)
            CMD_INFO, CMD_RESET: resp_len = LEN_INFO;
            CMD_STATUS:          resp_len = LEN_STATUS;
            CMD_READ:            resp_len = LEN_READ;
            CMD_WRITE:           resp_len = LEN_WRITE;
            default:             resp_len = LEN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/n64_tx_bit_timer.sv
// Phase timer for one line phase: low/high half of a data bit, or the stop bit.
// Latency: done rises exactly dur*US_CYCLES-1 cycles after load (phase lasts dur us).
// Backpressure: none; load restarts the count unconditionally.
module n64_tx_bit_timer
    import n64_pkg::*;
#(
    parameter int US_CYCLES = 16
) (
    input  logic sample_clk,
    input  logic reset,
    input  logic load,
    input  logic bit_val,
    input  logic stop,
    input  logic high_phase,
    output logic done
);

    localparam int CW = $clog2(3 * US_CYCLES);

    logic [CW-1:0] cnt;
    logic [CW-1:0] limit;
    logic [CW-1:0] limit_nxt;
    logic          long_phase;

    // A '1' has the long high phase, a '0' the long low phase; stop is 2 us low.
    always_comb begin
        long_phase = high_phase ? bit_val : ~bit_val;
        if (stop)
            limit_nxt = CW'(2 * US_CYCLES - 1);
        else if (long_phase)
            limit_nxt = CW'(3 * US_CYCLES - 1);
        else
            limit_nxt = CW'(US_CYCLES - 1);
    end

    // Count up from zero on each phase start and park at the terminal value.
    always_ff @(posedge sample_clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            limit <= '0;
        end else if (load) begin
            cnt   <= '0;
            limit <= limit_nxt;
        end else if (!done) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign done = (cnt == limit);

endmodule

// File: rtl/n64_controller_tx.sv
// N64 controller response transmitter: serialises the reply to a decoded command.
// Latency: cur_operation 2 cycles after handoff edge, first low bit TURNAROUND_US later.
// Backpressure: none; handoffs arriving while a response is in flight are dropped.
module n64_controller_tx
    import n64_pkg::*;
#(
    parameter int US_CYCLES     = 16,
    parameter int TURNAROUND_US = 2
) (
    input  logic        sample_clk,
    input  logic        reset,
    input  logic        tx_handoff,
    input  logic [7:0]  cmd,
    input  logic [31:0] buttons,
    input  logic [7:0]  crc,
    output logic [5:0]  rd_index,
    input  logic [7:0]  rd_byte,
    output logic        data_tx,
    output logic        cur_operation
);

    localparam int TURN_CYCLES = TURNAROUND_US * US_CYCLES;
    localparam int TW          = $clog2(TURN_CYCLES + 1);

    tx_state_t     state;
    logic          hand_q;
    logic          pend;
    logic [7:0]    cmd_q;
    logic [7:0]    crc_q;
    logic [31:0]   btn_q;
    logic [5:0]    byte_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    sh;
    logic [TW-1:0] turn_cnt;

    logic [5:0]    len;
    logic [7:0]    src_byte;
    logic          handoff_rise;
    logic          turn_done;
    logic          tmr_done;
    logic          last_bit;
    logic          last_byte;
    logic          load_byte;
    logic          tmr_load;
    logic          tmr_bit;
    logic          tmr_stop;
    logic          tmr_high;

    assign len          = resp_len(cmd_q);
    assign handoff_rise = tx_handoff & ~hand_q;
    assign turn_done    = (turn_cnt == TW'(TURN_CYCLES - 1));
    assign last_bit     = (bit_cnt == 3'd7);
    assign last_byte    = (byte_cnt == len);

    // Next byte to send; byte_cnt is the index of the byte about to be loaded.
    always_comb begin
        src_byte = 8'hFF;
        case (cmd_q)
            CMD_INFO, CMD_RESET: begin
                case (byte_cnt)
                    6'd0:    src_byte = INFO_B0;
                    6'd1:    src_byte = INFO_B1;
                    default: src_byte = INFO_B2;
                endcase
            end
            CMD_STATUS: begin
                case (byte_cnt[1:0])
                    2'd0:    src_byte = btn_q[31:24];
                    2'd1:    src_byte = btn_q[23:16];
                    2'd2:    src_byte = btn_q[15:8];
                    default: src_byte = btn_q[7:0];
                endcase
            end
            CMD_READ:  src_byte = rd_byte;
            CMD_WRITE: src_byte = crc_q;
            default:   src_byte = 8'hFF;
        endcase
    end

    // Phase-timer control: restart it on every phase change with the new phase's bit.
    always_comb begin
        load_byte = ((state == ST_TURN) && turn_done) ||
                    ((state == ST_HIGH) && tmr_done && last_bit && !last_byte);
        tmr_load  = ((state == ST_TURN) && turn_done) ||
                    (((state == ST_LOW) || (state == ST_HIGH)) && tmr_done);
        tmr_stop  = (state == ST_HIGH) && last_bit && last_byte;
        tmr_high  = (state == ST_LOW);
        if (load_byte)
            tmr_bit = src_byte[7];
        else if (state == ST_LOW)
            tmr_bit = sh[7];
        else
            tmr_bit = sh[6];
    end

    n64_tx_bit_timer #(
        .US_CYCLES (US_CYCLES)
    ) u_bit_timer (
        .sample_clk (sample_clk),
        .reset      (reset),
        .load       (tmr_load),
        .bit_val    (tmr_bit),
        .stop       (tmr_stop),
        .high_phase (tmr_high),
        .done       (tmr_done)
    );

    // Response FSM with byte/bit counters, shift register and registered line outputs.
    always_ff @(posedge sample_clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            data_tx       <= 1'b1;
            cur_operation <= 1'b0;
            rd_index      <= 6'd0;
            hand_q        <= 1'b1;
            pend          <= 1'b0;
            cmd_q         <= 8'h00;
            crc_q         <= 8'h00;
            btn_q         <= 32'h0;
            byte_cnt      <= 6'd0;
            bit_cnt       <= 3'd0;
            sh            <= 8'h00;
            turn_cnt      <= '0;
        end else begin
            hand_q <= tx_handoff;
            case (state)
                ST_IDLE: begin
                    if (pend) begin
                        pend <= 1'b0;
                        if (len != LEN_NONE) begin
                            state         <= ST_TURN;
                            cur_operation <= 1'b1;
                            turn_cnt      <= '0;
                            byte_cnt      <= 6'd0;
                            rd_index      <= 6'd0;
                        end
                    end else if (handoff_rise) begin
                        cmd_q <= cmd;
                        btn_q <= buttons;
                        crc_q <= crc;
                        pend  <= 1'b1;
                    end
                end
                ST_TURN: begin
                    if (turn_done) begin
                        state    <= ST_LOW;
                        data_tx  <= 1'b0;
                        sh       <= src_byte;
                        bit_cnt  <= 3'd0;
                        byte_cnt <= byte_cnt + 6'd1;
                        if (cmd_q == CMD_READ)
                            rd_index <= (byte_cnt == 6'd32) ? 6'd32 : byte_cnt + 6'd1;
                    end else begin
                        turn_cnt <= turn_cnt + TW'(1);
                    end
                end
                ST_LOW: begin
                    if (tmr_done) begin
                        state   <= ST_HIGH;
                        data_tx <= 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (tmr_done) begin
                        data_tx <= 1'b0;
                        if (!last_bit) begin
                            state   <= ST_LOW;
                            sh      <= {sh[6:0], 1'b0};
                            bit_cnt <= bit_cnt + 3'd1;
                        end else if (last_byte) begin
                            state <= ST_STOP;
                        end else begin
                            state    <= ST_LOW;
                            sh       <= src_byte;
                            bit_cnt  <= 3'd0;
                            byte_cnt <= byte_cnt + 6'd1;
                            if (cmd_q == CMD_READ)
                                rd_index <= (byte_cnt == 6'd32) ? 6'd32 : byte_cnt + 6'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if (tmr_done) begin
                        state         <= ST_IDLE;
                        data_tx       <= 1'b1;
                        cur_operation <= 1'b0;
                        rd_index      <= 6'd0;
                        byte_cnt      <= 6'd0;
                        bit_cnt       <= 3'd0;
                    end
                end
                default: begin
                    state         <= ST_IDLE;
                    data_tx       <= 1'b1;
                    cur_operation <= 1'b0;
                    rd_index      <= 6'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_n64_controller_tx.sv
// Directed bench for n64_controller_tx: decodes the line into bits and checks replies.
// Latency: n/a.
// Backpressure: n/a.
module tb_n64_controller_tx;

    logic        clk;
    logic        reset;
    logic        tx_handoff;
    logic [7:0]  cmd;
    logic [31:0] buttons;
    logic [7:0]  crc;
    logic [5:0]  rd_index;
    logic [7:0]  rd_byte;
    logic        data_tx;
    logic        cur_operation;

    int vectors     = 0;
    int miscompares = 0;

    logic rx_bits [0:299];
    int   rx_n, rx_bad, rx_turn, rx_stop, rx_started;
    int   rx_l0, rx_h0, rx_l1, rx_h1;
    int   rd_max = 0;

    n64_controller_tx #(
        .US_CYCLES     (4),
        .TURNAROUND_US (2)
    ) dut (
        .sample_clk    (clk),
        .reset         (reset),
        .tx_handoff    (tx_handoff),
        .cmd           (cmd),
        .buttons       (buttons),
        .crc           (crc),
        .rd_index      (rd_index),
        .rd_byte       (rd_byte),
        .data_tx       (data_tx),
        .cur_operation (cur_operation)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-payload source: byte value is three times its index.
    always_comb rd_byte = 8'({2'b00, rd_index} * 8'd3);

    // Highest rd_index ever presented.
    always @(negedge clk) if (32'(rd_index) > rd_max) rd_max = 32'(rd_index);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic [7:0] c);
        @(negedge clk);
        cmd        = c;
        tx_handoff = 1'b1;
        @(negedge clk);
        tx_handoff = 1'b0;
    endtask

    // Decode one response from the line: turnaround length, data bits, stop length.
    task automatic capture(input int bound);
        int l, h, t, done;
        rx_n = 0; rx_bad = 0; rx_turn = 0; rx_stop = 0; rx_started = 0;
        rx_l0 = 0; rx_h0 = 0; rx_l1 = 0; rx_h1 = 0;
        t = 0;
        while (!cur_operation && t < bound) begin
            @(negedge clk);
            t++;
        end
        if (!cur_operation) return;
        rx_started = 1;
        while (data_tx && cur_operation && rx_turn < 100) begin
            rx_turn++;
            @(negedge clk);
        end
        done = 0;
        while (done == 0) begin
            l = 0;
            while (!data_tx && l < 40) begin
                l++;
                @(negedge clk);
            end
            if (!cur_operation) begin
                rx_stop = l;
                done    = 1;
            end else begin
                h = 0;
                while (data_tx && cur_operation && h < 40) begin
                    h++;
                    @(negedge clk);
                end
                if (rx_n == 0) begin rx_l0 = l; rx_h0 = h; end
                if (rx_n == 1) begin rx_l1 = l; rx_h1 = h; end
                if (!cur_operation || h >= 40 || l >= 40) begin
                    rx_bad++;
                    done = 1;
                end else begin
                    if (l == 4 && h == 12)       rx_bits[rx_n] = 1'b1;
                    else if (l == 12 && h == 4)  rx_bits[rx_n] = 1'b0;
                    else begin
                        rx_bits[rx_n] = 1'b0;
                        rx_bad++;
                    end
                    rx_n++;
                    if (rx_n >= 300) done = 1;
                end
            end
        end
    endtask

    function automatic logic [31:0] bits_val(input int first, input int n);
        logic [31:0] v;
        v = 32'h0;
        for (int i = 0; i < n; i++) v = {v[30:0], rx_bits[first + i]};
        return v;
    endfunction

    initial begin
        int act;
        int errs;
        reset      = 1'b1;
        tx_handoff = 1'b0;
        cmd        = 8'h00;
        buttons    = 32'h0;
        crc        = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_data_tx", 32'(data_tx), 1);
        chk("reset_cur_op", 32'(cur_operation), 0);
        chk("reset_rd_index", 32'(rd_index), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Info command
        pulse(8'h00);
        capture(20);
        chk("info_started", rx_started, 1);
        chk("info_turn", rx_turn, 8);
        chk("info_nbits", rx_n, 24);
        chk("info_value", bits_val(0, 24), 32'h050002);
        chk("info_stop", rx_stop, 8);
        chk("info_bad", rx_bad, 0);
        chk("info_release", 32'(data_tx), 1);

        // Status command with a stray handoff mid-response
        buttons = 32'h8000_7F01;
        pulse(8'h01);
        fork
            capture(20);
            begin
                repeat (100) @(negedge clk);
                chk("status_rd_index", 32'(rd_index), 0);
                cmd        = 8'h03;
                tx_handoff = 1'b1;
                @(negedge clk);
                tx_handoff = 1'b0;
            end
        join
        chk("status_nbits", rx_n, 32);
        chk("status_value", bits_val(0, 32), 32'h8000_7F01);
        chk("status_bit0_low", rx_l0, 4);
        chk("status_bit0_high", rx_h0, 12);
        chk("status_bit1_low", rx_l1, 12);
        chk("status_bit1_high", rx_h1, 4);
        chk("status_bad", rx_bad, 0);
        act = 0;
        repeat (40) begin
            @(negedge clk);
            if (cur_operation || !data_tx) act++;
        end
        chk("stray_handoff_ignored", act, 0);

        // Read command: 33 bytes from rd_byte
        pulse(8'h02);
        capture(20);
        chk("read_nbits", rx_n, 264);
        errs = 0;
        for (int k = 0; k < 33; k++)
            if (bits_val(8 * k, 8) != 32'((k * 3) & 8'hFF)) errs++;
        chk("read_bytes_bad", errs, 0);
        chk("read_byte1", bits_val(8, 8), 32'h03);
        chk("read_byte31", bits_val(248, 8), 32'h5D);
        chk("read_byte32", bits_val(256, 8), 32'h60);
        chk("read_rd_max", rd_max, 32);
        chk("read_rd_index_after", 32'(rd_index), 0);
        chk("read_stop", rx_stop, 8);

        // Write command: CRC byte only
        crc = 8'hA5;
        pulse(8'h03);
        capture(20);
        chk("write_nbits", rx_n, 8);
        chk("write_value", bits_val(0, 8), 32'hA5);
        chk("write_stop", rx_stop, 8);
        chk("write_cur_op_after", 32'(cur_operation), 0);

        // Unknown command: no response
        pulse(8'h42);
        act = 0;
        repeat (30) begin
            @(negedge clk);
            if (cur_operation || !data_tx) act++;
        end
        chk("unknown_cmd_quiet", act, 0);

        // Reset command answers like info
        pulse(8'hFF);
        capture(20);
        chk("reset_cmd_value", bits_val(0, 24), 32'h050002);
        chk("reset_cmd_nbits", rx_n, 24);

        // Reset in the low phase of bit 10 of a status response
        pulse(8'h01);
        repeat (172) @(negedge clk);
        chk("midreset_pre_low", 32'(data_tx), 0);
        chk("midreset_pre_busy", 32'(cur_operation), 1);
        reset = 1'b1;
        #1;
        chk("midreset_data_tx", 32'(data_tx), 1);
        chk("midreset_cur_op", 32'(cur_operation), 0);
        chk("midreset_rd_index", 32'(rd_index), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        crc = 8'h3C;
        pulse(8'h03);
        capture(20);
        chk("after_reset_nbits", rx_n, 8);
        chk("after_reset_value", bits_val(0, 8), 32'h3C);

        // Handoff already high when reset releases must not start a response
        @(negedge clk);
        reset      = 1'b1;
        cmd        = 8'h03;
        tx_handoff = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        act   = 0;
        repeat (20) begin
            @(negedge clk);
            if (cur_operation || !data_tx) act++;
        end
        chk("held_handoff_ignored", act, 0);
        tx_handoff = 1'b0;
        @(negedge clk);
        crc = 8'h81;
        pulse(8'h03);
        capture(20);
        chk("fresh_edge_value", bits_val(0, 8), 32'h81);
        chk("fresh_edge_nbits", rx_n, 8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/n64_controller_tx.md
N64_CONTROLLER_TX -- requirements
Module: n64_controller_tx

Interface
REQ-001 SHALL have parameter US_CYCLES, default 16, sample_clk cycles per 1 us on the line.
REQ-002 SHALL have parameter TURNAROUND_US, default 2, idle microseconds between handoff and first driven bit.
REQ-003 sample_clk  in  1  single clock; all logic on posedge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 tx_handoff  in  1  rx has finished a command; rising edge starts a response.
REQ-006 cmd  in  8  decoded command code from rx.
REQ-007 buttons  in  32  button status; [31:24] sent first.
REQ-008 crc  in  8  write-data CRC from rx.
REQ-009 rd_index  out  6  read-payload byte index, 0..32.
REQ-010 rd_byte  in  8  payload byte for rd_index, combinational from the source; index 32 carries the data CRC.
REQ-011 data_tx  out  1  line drive: 0 = pull low, 1 = release.
REQ-012 cur_operation  out  1  high while a response is in progress; feeds rx cur_operation.

Function
REQ-013 SHALL detect a tx_handoff rising edge using a registered copy; a handoff while cur_operation=1 SHALL be ignored.
REQ-014 On handoff, SHALL latch cmd, buttons and crc, then set cur_operation=1 on the next cycle.
REQ-015 Response sets: 0x00/0xFF -> 3 bytes 0x05,0x00,0x02; 0x01 -> 4 bytes from buttons, MSB first; 0x02 -> 33 bytes rd_byte[0..32]; 0x03 -> 1 byte crc.
REQ-016 Any other cmd SHALL produce no response; cur_operation stays 0 and data_tx stays 1.
REQ-017 States: IDLE -> TURN (TURNAROUND_US*US_CYCLES cycles) -> LOW -> HIGH -> (next bit LOW | STOP) -> IDLE.
REQ-018 Bits SHALL be sent MSB first per byte; bit 0 = 3 us low + 1 us high; bit 1 = 1 us low + 3 us high.
REQ-019 After the last bit, SHALL send the stop bit (2 us low), then release the line and return to IDLE.
REQ-020 A byte SHALL be loaded from its source on the cycle TURN or the previous byte's last HIGH ends; for 0x02, rd_index SHALL equal the byte number on that cycle.
REQ-021 rd_index SHALL hold 0 outside a 0x02 response.
REQ-022 The byte counter SHALL be 6 bits wide and the bit counter 3 bits wide; the last byte is detected by compare, never by wrap.
REQ-023 The phase timer SHALL count 0..(3*US_CYCLES-1), reloading on every phase change.
REQ-024 cur_operation SHALL fall on the same cycle that data_tx is released after STOP.
REQ-025 data_tx SHALL be 1 in IDLE and TURN.

Reset
REQ-026 Reset SHALL force state=IDLE, data_tx=1, cur_operation=0, rd_index=0 and clear all counters and latched inputs immediately, including mid-response.
REQ-027 After reset deasserts, a tx_handoff already high SHALL NOT start a response; only a fresh rising edge does.

Structure
REQ-028 Package n64_pkg SHALL hold the command codes (INFO 0x00, STATUS 0x01, READ 0x02, WRITE 0x03, RESET 0xFF), the info bytes, and the response-length constants.
REQ-029 One sub-module, n64_tx_bit_timer, SHALL generate the LOW/HIGH phase durations for one bit or the stop bit, with a done pulse.
REQ-030 The top SHALL hold the response FSM, byte/bit counters and the shift register.

Verification (US_CYCLES=4, TURNAROUND_US=2)
REQ-031 cmd=0x00, pulse handoff -> 8 idle cycles, then 24 bits 0x05,0x00,0x02 and a 2 us stop; cur_operation high throughout.
REQ-032 cmd=0x01, buttons=0x8000_7F01 -> first bit 4 cycles low/12 high, second bit 12 low/4 high; 32 bits total.
REQ-033 cmd=0x02, rd_byte=rd_index*3 -> bytes 0x00,0x03..0x5D, then the index-32 byte; rd_index steps 0..32.
REQ-034 cmd=0x03, crc=0xA5 -> 8 bits 10100101 + stop, then cur_operation=0.
REQ-035 cmd=0x42 -> no line activity; a second handoff during a 0x01 response -> ignored, exactly 32 bits sent.
REQ-036 Assert reset at bit 10 of a 0x01 response -> data_tx=1 and cur_operation=0 immediately; the next handoff starts a fresh response.
